// File: rtl/jump_pkg.sv
// Shared definitions for the jump stage of the game datapath.
// Holds the jump FSM state type, the landing result codes, the
// screen limit and the man/stage coordinate width.
package jump_pkg;

  localparam int COORD_W = 10;

  // Rightmost pixel the man may occupy on screen.
  localparam logic [COORD_W-1:0] X_MAX = 10'd639;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHARGE = 3'd1,
    FLIGHT = 3'd2,
    JUDGE  = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_STAY = 2'b01,
    RES_ADV  = 2'b10,
    RES_FALL = 2'b11
  } result_e;

endpackage

// File: rtl/press_sync.sv
// Button synchronizer for the jump stage.
// Brings the raw, asynchronous button level into the clk domain with two
// flops and produces one-clk rise/fall pulses from the synchronized level.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   press               raw button level (asynchronous)
//   press_rise/_fall    one-clk pulses on synchronized press/release
module press_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic press,
  output logic press_rise,
  output logic press_fall
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two metastability flops followed by one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= press;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press_rise = sync2_q & ~prev_q;
  assign press_fall = ~sync2_q & prev_q;

endmodule

// File: rtl/jump_ctrl.sv
// Jump stage: turns a button hold into a charge, flies the man along an
// integer parabola one step per animation pulse, then judges the landing
// against the current and next stage centres.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pulse           one-clk animation tick
//   enable          jump phase granted by the top FSM; low forces IDLE
//   press           raw button level (asynchronous)
//   man_x_in        man x position, tracked while IDLE
//   stage_x[0:1]    centre x of current (0) and next (1) stage
//   man_x, man_y    man position (man_y is height above stage top)
//   charge          charge value for the power bar
//   jump_fin        high in DONE until enable drops
//   result          landing result (none / stay / advance / fall)
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int MAX_CHARGE   = 40,
  parameter int X_STEP       = 2,
  parameter int STAGE_HALF_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pulse,
  input  logic               enable,
  input  logic               press,
  input  logic [COORD_W-1:0] man_x_in,
  input  logic [COORD_W-1:0] stage_x [0:1],
  output logic [COORD_W-1:0] man_x,
  output logic [COORD_W-1:0] man_y,
  output logic [5:0]         charge,
  output logic               jump_fin,
  output logic [1:0]         result
);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  man_x_q, man_x_d;
  logic [COORD_W-1:0]  man_y_q, man_y_d;
  logic [5:0]          charge_q, charge_d;
  logic [5:0]          cnt_q, cnt_d;
  logic signed [7:0]   vy_q, vy_d;
  logic [1:0]          result_q, result_d;

  logic                press_rise;
  logic                press_fall;

  press_sync u_press_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .press      (press),
    .press_rise (press_rise),
    .press_fall (press_fall)
  );

  // Horizontal step with clamp at the right screen edge.
  logic [COORD_W:0]    x_sum;
  logic [COORD_W-1:0]  x_next;
  assign x_sum  = {1'b0, man_x_q} + (COORD_W+1)'(X_STEP);
  assign x_next = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[COORD_W-1:0];

  // The velocity sequence never drives the height negative, so a 10-bit
  // wrapping add gives the same result as the truncated 11-bit signed sum.
  logic [COORD_W-1:0]  y_next;
  assign y_next = man_y_q + {{2{vy_q[7]}}, vy_q};

  // Signed 11-bit landing offsets; bit 10 is the sign.
  logic [COORD_W:0]    d0, d1, abs_d0, abs_d1;
  assign d0     = {1'b0, man_x_q} - {1'b0, stage_x[0]};
  assign d1     = {1'b0, man_x_q} - {1'b0, stage_x[1]};
  assign abs_d0 = d0[COORD_W] ? (~d0 + 1'b1) : d0;
  assign abs_d1 = d1[COORD_W] ? (~d1 + 1'b1) : d1;

  always_comb begin
    state_d  = state_q;
    man_x_d  = man_x_q;
    man_y_d  = man_y_q;
    charge_d = charge_q;
    cnt_d    = cnt_q;
    vy_d     = vy_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        man_x_d  = man_x_in;
        man_y_d  = '0;
        charge_d = '0;
        cnt_d    = '0;
        vy_d     = '0;
        result_d = RES_NONE;
        if (press_rise) state_d = CHARGE;
      end
      CHARGE: begin
        // Release takes precedence over a coincident pulse.
        if (press_fall) begin
          state_d = FLIGHT;
          cnt_d   = charge_q;
          vy_d    = $signed({2'b00, charge_q}) - 8'sd1;
        end else if (pulse && (charge_q < 6'(MAX_CHARGE))) begin
          charge_d = charge_q + 6'd1;
        end
      end
      FLIGHT: begin
        if (cnt_q == '0) begin
          state_d = JUDGE;
        end else if (pulse) begin
          man_y_d = y_next;
          vy_d    = vy_q - 8'sd2;
          man_x_d = x_next;
          cnt_d   = cnt_q - 6'd1;
        end
      end
      JUDGE: begin
        // Next stage wins when both stage tops overlap the landing point.
        if (abs_d1 <= (COORD_W+1)'(STAGE_HALF_W))      result_d = RES_ADV;
        else if (abs_d0 <= (COORD_W+1)'(STAGE_HALF_W)) result_d = RES_STAY;
        else                                           result_d = RES_FALL;
        state_d = DONE;
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d  = IDLE;
      man_x_d  = man_x_in;
      man_y_d  = '0;
      charge_d = '0;
      cnt_d    = '0;
      vy_d     = '0;
      result_d = RES_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      man_x_q  <= '0;
      man_y_q  <= '0;
      charge_q <= '0;
      cnt_q    <= '0;
      vy_q     <= '0;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      man_x_q  <= man_x_d;
      man_y_q  <= man_y_d;
      charge_q <= charge_d;
      cnt_q    <= cnt_d;
      vy_q     <= vy_d;
      result_q <= result_d;
    end
  end

  assign man_x    = man_x_q;
  assign man_y    = man_y_q;
  assign charge   = charge_q;
  assign result   = result_q;
  assign jump_fin = (state_q == DONE);

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: a closed-form reference model of the
// jump (height from pulse index, x from start point) is compared to the DUT
// every clock, with directed scenarios plus randomized jumps.
module tb_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse;
  logic       enable;
  logic       press;
  logic [9:0] man_x_in;
  logic [9:0] stage_x [0:1];
  logic [9:0] man_x;
  logic [9:0] man_y;
  logic [5:0] charge;
  logic       jump_fin;
  logic [1:0] result;

  int errors = 0;
  int checks = 0;

  localparam int P_IDLE = 0, P_CHARGE = 1, P_FLIGHT = 2, P_JUDGE = 3, P_DONE = 4;

  int   mPhase, mX, mY, mCharge, mRes, mC, mK, mX0, mD0, mD1;
  logic ph0, ph1, ph2, mRise, mFall;

  int expY [10] = '{9, 16, 21, 24, 25, 24, 21, 16, 9, 0};

  always #5 clk = ~clk;

  jump_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse    (pulse),
    .enable   (enable),
    .press    (press),
    .man_x_in (man_x_in),
    .stage_x  (stage_x),
    .man_x    (man_x),
    .man_y    (man_y),
    .charge   (charge),
    .jump_fin (jump_fin),
    .result   (result)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: press edges are seen two clocks after the press level;
  // flight height after k pulses with charge C is k*C - k*k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = P_IDLE; mX = 0; mY = 0; mCharge = 0; mRes = 0;
      mC = 0; mK = 0; mX0 = 0;
      ph0 = 1'b0; ph1 = 1'b0; ph2 = 1'b0;
    end else begin
      mRise = ph1 & ~ph2;
      mFall = ~ph1 & ph2;
      ph2 = ph1; ph1 = ph0; ph0 = press;
      if (!enable) begin
        mPhase = P_IDLE; mX = int'(man_x_in); mY = 0; mCharge = 0; mRes = 0;
      end else begin
        case (mPhase)
          P_IDLE: begin
            mX = int'(man_x_in); mY = 0; mCharge = 0; mRes = 0;
            if (mRise) mPhase = P_CHARGE;
          end
          P_CHARGE: begin
            if (mFall) begin
              mPhase = P_FLIGHT; mC = mCharge; mK = 0; mX0 = mX;
            end else if (pulse && mCharge < 40) begin
              mCharge++;
            end
          end
          P_FLIGHT: begin
            if (mK == mC) mPhase = P_JUDGE;
            else if (pulse) begin
              mK++;
              mY = mK * mC - mK * mK;
              mX = mX0 + 2 * mK;
              if (mX > 639) mX = 639;
            end
          end
          P_JUDGE: begin
            mD0 = mX - int'(stage_x[0]); if (mD0 < 0) mD0 = -mD0;
            mD1 = mX - int'(stage_x[1]); if (mD1 < 0) mD1 = -mD1;
            if (mD1 <= 20)      mRes = 2;
            else if (mD0 <= 20) mRes = 1;
            else                mRes = 3;
            mPhase = P_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("man_x",    32'(man_x),    32'(mX));
      checkOutput("man_y",    32'(man_y),    32'(mY));
      checkOutput("charge",   32'(charge),   32'(mCharge));
      checkOutput("result",   32'(result),   32'(mRes));
      checkOutput("jump_fin", 32'(jump_fin), 32'(mPhase == P_DONE));
    end
  end

  task automatic cycle(input logic p);
    pulse = p;
    @(negedge clk);
    pulse = 1'b0;
  endtask

  // Leave the previous jump, then press and charge for hold pulses.
  task automatic applyStimulus(input int x0, input int s0, input int s1, input int hold, input int gap);
    enable = 1'b0; press = 1'b0;
    cycle(1'b0);
    man_x_in = 10'(x0); stage_x[0] = 10'(s0); stage_x[1] = 10'(s1);
    enable = 1'b1;
    repeat (3) cycle(1'b0);
    press = 1'b1;
    repeat (3) cycle(1'b0);
    repeat (hold) begin
      cycle(1'b1);
      repeat (gap) cycle(1'b0);
    end
  endtask

  // Release; lastPulse puts a pulse on the clock where the release lands.
  task automatic releasePress(input logic lastPulse);
    press = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    cycle(lastPulse);
  endtask

  task automatic flyToEnd(input int gap, output int peak);
    int i;
    peak = 0;
    i = 0;
    while (jump_fin !== 1'b1 && i < 2000) begin
      cycle((i % (gap + 1)) == 0);
      if (int'(man_y) > peak) peak = int'(man_y);
      i++;
    end
    if (jump_fin !== 1'b1) checkOutput("fin_timeout", 32'(jump_fin), 32'd1);
  endtask

  initial begin
    int pk, x0, s1, hold, gap;
    rst_n = 1'b0; enable = 1'b0; press = 1'b0; pulse = 1'b0;
    man_x_in = 10'd33; stage_x[0] = 10'd0; stage_x[1] = 10'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_man_x", 32'(man_x), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0);
    checkOutput("idle_tracks_x", 32'(man_x), 32'd33);

    // Nominal jump landing on the next stage.
    applyStimulus(60, 60, 80, 10, 1);
    releasePress(1'b0);
    checkOutput("nom_charge", 32'(charge), 32'd10);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1);
      checkOutput("nom_y", 32'(man_y), 32'(expY[i]));
    end
    flyToEnd(0, pk);
    checkOutput("nom_x", 32'(man_x), 32'd80);
    checkOutput("nom_res", 32'(result), 32'd2);
    repeat (3) cycle(1'b1);
    checkOutput("nom_fin_hold", 32'(jump_fin), 32'd1);
    press = 1'b1;
    repeat (4) cycle(1'b0);
    enable = 1'b0;
    cycle(1'b0);
    checkOutput("nom_fin_drop", 32'(jump_fin), 32'd0);
    enable = 1'b1;
    repeat (6) cycle(1'b1);
    checkOutput("held_no_retrig", 32'(charge), 32'd0);

    // Stay on current stage, then fall.
    applyStimulus(60, 60, 150, 10, 0);
    releasePress(1'b0);
    flyToEnd(1, pk);
    checkOutput("stay_res", 32'(result), 32'd1);
    applyStimulus(60, 60, 150, 25, 0);
    releasePress(1'b0);
    flyToEnd(0, pk);
    checkOutput("fall_x", 32'(man_x), 32'd110);
    checkOutput("fall_res", 32'(result), 32'd3);

    // Saturation.
    applyStimulus(100, 0, 180, 60, 1);
    releasePress(1'b0);
    checkOutput("sat_charge", 32'(charge), 32'd40);
    flyToEnd(2, pk);
    checkOutput("sat_peak", 32'(pk), 32'd400);
    checkOutput("sat_x", 32'(man_x), 32'd180);
    checkOutput("sat_y", 32'(man_y), 32'd0);

    // Zero charge.
    applyStimulus(60, 60, 150, 0, 0);
    releasePress(1'b0);
    flyToEnd(0, pk);
    checkOutput("zero_x", 32'(man_x), 32'd60);
    checkOutput("zero_res", 32'(result), 32'd1);

    // Release coinciding with a pulse.
    applyStimulus(200, 0, 0, 5, 2);
    releasePress(1'b1);
    checkOutput("rel_pulse_charge", 32'(charge), 32'd5);
    flyToEnd(0, pk);

    // Enable abort at flight pulse 3, then a fresh charge.
    applyStimulus(60, 60, 80, 10, 0);
    releasePress(1'b0);
    cycle(1'b1); cycle(1'b0); cycle(1'b1);
    man_x_in = 10'd300;
    enable = 1'b0;
    cycle(1'b1);
    checkOutput("abort_x", 32'(man_x), 32'd300);
    checkOutput("abort_y", 32'(man_y), 32'd0);
    checkOutput("abort_res", 32'(result), 32'd0);
    enable = 1'b1;
    press = 1'b1;
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    checkOutput("abort_recharge", 32'(charge), 32'd1);

    // Reset mid-flight.
    applyStimulus(400, 0, 0, 20, 0);
    releasePress(1'b0);
    repeat (4) cycle(1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_x", 32'(man_x), 32'd0);
    checkOutput("rst_mid_y", 32'(man_y), 32'd0);
    checkOutput("rst_mid_charge", 32'(charge), 32'd0);
    checkOutput("rst_mid_fin", 32'(jump_fin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b1);

    // Randomized jumps, with man_x_in and press disturbed during flight.
    for (int n = 0; n < 30; n++) begin
      x0   = $urandom_range(0, 639);
      hold = $urandom_range(0, 50);
      gap  = $urandom_range(0, 3);
      s1   = x0 + 2 * (hold > 40 ? 40 : hold) + $urandom_range(0, 60) - 30;
      if (s1 < 0) s1 = 0;
      if (s1 > 639) s1 = 639;
      applyStimulus(x0, x0 + $urandom_range(0, 40) - 20 < 0 ? 0 : x0 + $urandom_range(0, 40) - 20 > 639 ? 639 : x0 + $urandom_range(0, 40) - 20, s1, hold, gap);
      releasePress(1'(($urandom_range(0, 1))));
      man_x_in = 10'($urandom_range(0, 639));
      press = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 30)) cycle(1'($urandom_range(0, 1)));
        enable = 1'b0;
        cycle(1'b0);
      end else begin
        flyToEnd(gap, pk);
        repeat ($urandom_range(0, 4)) cycle(1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
